// File: rtl/psc_trigger_mux.sv
// Multi-channel EVR trigger to PSC serial frame multiplexer with round-robin arbitration.
// Optional even-parity bit before the stop bit when PSC_TRIGGER_PARITY_EN is defined.
module psc_trigger_mux #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned CLK_DIV         = 10,
  parameter int unsigned FRAME_BITS      = 8,
  parameter int unsigned TRIG_ACTIVE_LOW = 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [CHANNELS-1:0]                               evr_trigger,
  input  logic [CHANNELS-1:0]                               enable,
  input  logic [CHANNELS*FRAME_BITS-1:0]                    trig_code,
  input  logic                                              overrun_clr,
  output logic                                              psc_output,
  output logic                                              busy,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] active_ch,
  output logic [CHANNELS-1:0]                               overrun
);

  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam logic [CHANNELS-1:0] IDLE_LVL = (TRIG_ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PSC_TRIGGER_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [CHANNELS-1:0]   sync1_q, sync2_q, prev_q, edge_q;
  logic [CHANNELS-1:0]   asrt_now_c, asrt_prev_c;
  logic [CHANNELS-1:0]   pending_q, pending_nxt, req_c, ev_c, grant_oh_c, ovr_set_c;
  logic [CHANNELS-1:0]   overrun_nxt;
  logic [CW-1:0]         ptr_q, ptr_nxt, grant_ch_c, active_nxt;
  logic                  arb_found_c, grant_c;
  logic [FRAME_BITS-1:0] code_sel_c, shift_q, shift_nxt;
  logic [2:0]            state_q, state_nxt;
  logic [TW-1:0]         timer_q, timer_nxt;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_nxt;
  logic                  psc_nxt, busy_nxt, timer_last_c;
`ifdef PSC_TRIGGER_PARITY_EN
  logic                  parity_q, parity_nxt;
`endif

  // Two-flop synchroniser, history flop and registered edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
      prev_q  <= IDLE_LVL;
      edge_q  <= '0;
    end else begin
      sync1_q <= evr_trigger;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= asrt_now_c & ~asrt_prev_c;
    end
  end

  assign asrt_now_c  = (TRIG_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign asrt_prev_c = (TRIG_ACTIVE_LOW != 0) ? ~prev_q  : prev_q;
  assign req_c       = pending_q & enable;
  assign ev_c        = edge_q & enable;

  // Round-robin: first requester at or after the pointer, then wrap below it
  always_comb begin
    arb_found_c = 1'b0;
    grant_ch_c  = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (!arb_found_c && req_c[c] && (CW'(c) >= ptr_q)) begin
        arb_found_c = 1'b1;
        grant_ch_c  = CW'(c);
      end
    end
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (!arb_found_c && req_c[c] && (CW'(c) < ptr_q)) begin
        arb_found_c = 1'b1;
        grant_ch_c  = CW'(c);
      end
    end
  end

  always_comb begin
    code_sel_c = '0;
    grant_oh_c = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (grant_ch_c == CW'(c)) begin
        code_sel_c    = trig_code[c*FRAME_BITS +: FRAME_BITS];
        grant_oh_c[c] = grant_c;
      end
    end
  end

  assign timer_last_c = (timer_q == '0);

  // Frame sequencer next-state logic
  always_comb begin
    state_nxt   = state_q;
    timer_nxt   = timer_q;
    bit_cnt_nxt = bit_cnt_q;
    shift_nxt   = shift_q;
    grant_c     = 1'b0;
    case (state_q)
      S_IDLE: grant_c = |req_c;
      S_START: begin
        if (timer_last_c) begin
          state_nxt   = S_DATA;
          timer_nxt   = TW'(CLK_DIV - 1);
          bit_cnt_nxt = '0;
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (timer_last_c) begin
          timer_nxt   = TW'(CLK_DIV - 1);
          shift_nxt   = shift_q >> 1;
          bit_cnt_nxt = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
`ifdef PSC_TRIGGER_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
`ifdef PSC_TRIGGER_PARITY_EN
      S_PARITY: begin
        if (timer_last_c) begin
          state_nxt = S_STOP;
          timer_nxt = TW'(CLK_DIV - 1);
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (timer_last_c) begin
          state_nxt = S_IDLE;
          grant_c   = |req_c;
        end else begin
          timer_nxt = timer_q - TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (grant_c) begin
      state_nxt = S_START;
      timer_nxt = TW'(CLK_DIV - 1);
      shift_nxt = code_sel_c;
    end
  end

  // Pending, overrun, pointer and registered line outputs
  always_comb begin
    pending_nxt = enable & (ev_c | (pending_q & ~grant_oh_c));
    ovr_set_c   = ev_c & pending_q & ~grant_oh_c;
    overrun_nxt = (overrun & ~{CHANNELS{overrun_clr}}) | ovr_set_c;
    ptr_nxt     = ptr_q;
    active_nxt  = active_ch;
    if (grant_c) begin
      ptr_nxt    = (grant_ch_c == CW'(CHANNELS - 1)) ? '0 : grant_ch_c + CW'(1);
      active_nxt = grant_ch_c;
    end
`ifdef PSC_TRIGGER_PARITY_EN
    parity_nxt = grant_c ? ^code_sel_c : parity_q;
`endif
    busy_nxt = (state_nxt != S_IDLE);
    case (state_nxt)
      S_START:  psc_nxt = 1'b0;
      S_DATA:   psc_nxt = shift_nxt[0];
`ifdef PSC_TRIGGER_PARITY_EN
      S_PARITY: psc_nxt = parity_nxt;
`endif
      default:  psc_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pending_q  <= '0;
      overrun    <= '0;
      ptr_q      <= '0;
      active_ch  <= '0;
      psc_output <= 1'b1;
      busy       <= 1'b0;
`ifdef PSC_TRIGGER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      timer_q    <= timer_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      shift_q    <= shift_nxt;
      pending_q  <= pending_nxt;
      overrun    <= overrun_nxt;
      ptr_q      <= ptr_nxt;
      active_ch  <= active_nxt;
      psc_output <= psc_nxt;
      busy       <= busy_nxt;
`ifdef PSC_TRIGGER_PARITY_EN
      parity_q   <= parity_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_psc_trigger_mux.sv
// Directed bench for psc_trigger_mux: latency, frame shape, arbitration, overrun, reset, enable.
module tb_psc_trigger_mux;

  localparam int DIV = 10;
  localparam int FB  = 8;
`ifdef PSC_TRIGGER_PARITY_EN
  localparam int NBITS = FB + 3;
`else
  localparam int NBITS = FB + 2;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  evr_trigger;
  logic [3:0]  enable;
  logic [31:0] trig_code;
  logic        overrun_clr;
  logic        psc_output;
  logic        busy;
  logic [1:0]  active_ch;
  logic [3:0]  overrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int start = 0;
  int saw   = 0;

  psc_trigger_mux #(
    .CHANNELS(4), .CLK_DIV(DIV), .FRAME_BITS(FB), .TRIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .evr_trigger(evr_trigger), .enable(enable),
    .trig_code(trig_code), .overrun_clr(overrun_clr), .psc_output(psc_output),
    .busy(busy), .active_ch(active_ch), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      tick();
      if (busy !== 1'b0 || psc_output !== 1'b1) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic wait_busy(input string tag, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_busy_rise"}, busy, 1);
  endtask

  // Called on the first cycle of a start bit; leaves on the cycle after the stop bit
  task automatic expect_frame(input string tag, input logic [7:0] code, input int ch);
    logic exp_bit;
    int   bad;
    check({tag, "_active_ch"}, active_ch, ch);
    for (int b = 0; b < NBITS; b++) begin
      if (b == 0)             exp_bit = 1'b0;
      else if (b <= FB)       exp_bit = code[b-1];
      else if (b == NBITS-1)  exp_bit = 1'b1;
      else                    exp_bit = ^code;
      bad = 0;
      for (int c = 0; c < DIV; c++) begin
        if (psc_output !== exp_bit || busy !== 1'b1) bad++;
        tick();
      end
      check($sformatf("%s_bit%0d", tag, b), bad, 0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    evr_trigger = 4'hF;
    enable      = 4'hF;
    overrun_clr = 1'b0;
    trig_code   = {8'h3C, 8'h22, 8'h11, 8'hA5};

    // Reset state and quiet release
    repeat (5) tick();
    check("reset_psc", psc_output, 1);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_active_ch", active_ch, 0);
    reset = 1'b0;
    idle_check("no_frame_after_reset", 30);

    // Single trigger: start bit appears on the fifth sample after the fall
    evr_trigger[0] = 1'b0;
    saw = 0;
    repeat (4) begin
      tick();
      if (psc_output !== 1'b1 || busy !== 1'b0) saw++;
    end
    check("single_latency_idle", saw, 0);
    tick();
    check("single_start_psc", psc_output, 0);
    check("single_start_busy", busy, 1);
    expect_frame("single", 8'hA5, 0);
    check("single_end_busy", busy, 0);
    evr_trigger[0] = 1'b1;
    repeat (8) tick();

    // Simultaneous ch1+ch2 with pointer at 1: back-to-back frames
    evr_trigger[2:1] = 2'b00;
    wait_busy("simul", 20);
    expect_frame("simul_a", 8'h11, 1);
    expect_frame("simul_b", 8'h22, 2);
    check("simul_end_busy", busy, 0);
    evr_trigger[2:1] = 2'b11;
    repeat (8) tick();

    // Pointer at 3 wraps to ch1
    evr_trigger[1] = 1'b0;
    wait_busy("wrap", 20);
    expect_frame("wrap", 8'h11, 1);
    evr_trigger[1] = 1'b1;
    repeat (8) tick();

    // Pointer at 2: ch2 wins, then ch1
    evr_trigger[2:1] = 2'b00;
    wait_busy("rr", 20);
    expect_frame("rr_a", 8'h22, 2);
    expect_frame("rr_b", 8'h11, 1);
    check("rr_end_busy", busy, 0);
    evr_trigger[2:1] = 2'b11;
    repeat (8) tick();

    // Overrun: two ch3 falls during a ch0 frame
    evr_trigger[0] = 1'b0;
    wait_busy("ovr", 20);
    start = cyc;
    check("ovr_ch0_active", active_ch, 0);
    repeat (3) tick();
    evr_trigger[3] = 1'b0;
    repeat (5) tick();
    evr_trigger[3] = 1'b1;
    repeat (5) tick();
    evr_trigger[3] = 1'b0;
    repeat (8) tick();
    check("overrun_set", overrun, 4'h8);
    saw = 0;
    while (cyc - start < NBITS*DIV) begin
      if (busy !== 1'b1) saw++;
      tick();
    end
    check("ovr_ch0_busy_len", saw, 0);
    expect_frame("ovr_ch3", 8'h3C, 3);
    check("ovr_end_busy", busy, 0);
    idle_check("ovr_single_frame", 40);
    check("overrun_sticky", overrun, 4'h8);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_cleared", overrun, 0);
    evr_trigger = 4'hF;
    repeat (8) tick();

    // Reset mid-frame with another channel pending
    evr_trigger[0] = 1'b0;
    wait_busy("midrst", 20);
    start = cyc;
    repeat (3) tick();
    evr_trigger[0] = 1'b1;
    evr_trigger[1] = 1'b0;
    repeat (8) tick();
    evr_trigger[1] = 1'b1;
    while (cyc - start < 40) tick();
    check("midrst_bit_before", psc_output, 0);
    reset = 1'b1;
    tick();
    check("midrst_psc", psc_output, 1);
    check("midrst_busy", busy, 0);
    tick();
    reset = 1'b0;
    idle_check("midrst_no_resume", 150);
    check("midrst_active_ch", active_ch, 0);

    // Disabled channel ignores its edge
    enable[2]      = 1'b0;
    evr_trigger[2] = 1'b0;
    idle_check("disabled_edge", 20);
    evr_trigger[2] = 1'b1;
    enable[2]      = 1'b1;
    repeat (8) tick();

    // Dropping enable drops a queued request
    evr_trigger[0] = 1'b0;
    wait_busy("endrop", 20);
    start = cyc;
    repeat (5) tick();
    evr_trigger[1] = 1'b0;
    repeat (10) tick();
    enable[1] = 1'b0;
    tick();
    enable[1] = 1'b1;
    while (cyc - start < NBITS*DIV) tick();
    check("endrop_end_busy", busy, 0);
    idle_check("endrop_no_frame", 20);
    evr_trigger = 4'hF;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
